// File: rtl/jam_pkg.sv
// Shared constants and state encoding for the cost loader and the permutation/cost block.
package jam_pkg;
    localparam int JAM_N      = 8;
    localparam int JAM_COST_W = 7;
    localparam int CNT_W      = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;
endpackage

// File: rtl/cost_table_rf.sv
// N*N x COST_W cost register file: one write port, one registered read port (read-old on collision).
module cost_table_rf #(
    parameter int DEPTH  = 64,
    parameter int WIDTH  = 7,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;

    always_comb begin
        rdata_d = mem_q[raddr];
    end

    // Storage has no reset so it maps onto RAM; only the output register clears.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/cost_loader.sv
// Streams an N x N cost table in row-major order into a register file and serves 1-cycle lookups.
// Optional feature macro: COST_LOADER_ROWMIN_EN adds the per-row minimum output RowMin.
module cost_loader
    import jam_pkg::*;
#(
    parameter int N      = JAM_N,
    parameter int COST_W = JAM_COST_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [COST_W-1:0] in_data,
    output logic              Load_done,
    input  logic [2:0]        W,
    input  logic [2:0]        J,
    output logic [COST_W-1:0] Cost
`ifdef COST_LOADER_ROWMIN_EN
    ,
    output logic [COST_W-1:0] RowMin
`endif
);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N * N - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              load_done_q, load_done_d;
    logic              accept;
    logic [CNT_W-1:0]  rd_addr;

    // Reset also blocks the handshake so nothing is accepted on the reset edge.
    assign in_ready = (state_q == LOAD) && !clr && !RST;
    assign accept   = in_valid && in_ready;
    assign rd_addr  = CNT_W'(W) * CNT_W'(N) + CNT_W'(J);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: state_d = LOAD;
            LOAD: begin
                if (clr) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (accept) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_IDX) begin
                        state_d = READY;
                    end
                end
            end
            READY: begin
                if (clr) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        load_done_d = (state_d == READY);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            load_done_q <= load_done_d;
        end
    end

    assign Load_done = load_done_q;

    cost_table_rf #(
        .DEPTH  (N * N),
        .WIDTH  (COST_W),
        .ADDR_W (CNT_W)
    ) u_table (
        .clk   (CLK),
        .srst  (RST),
        .we    (accept),
        .waddr (cnt_q),
        .wdata (in_data),
        .raddr (rd_addr),
        .rdata (Cost)
    );

`ifdef COST_LOADER_ROWMIN_EN
    logic [COST_W-1:0] row_min_q [N];
    logic [COST_W-1:0] row_min_d [N];
    logic [COST_W-1:0] rowmin_out_q, rowmin_out_d;
    logic [2:0]        wr_row;
    logic              wr_first;

    assign wr_row   = 3'(cnt_q / CNT_W'(N));
    assign wr_first = ((cnt_q % CNT_W'(N)) == '0);

    // The first entry of a row seeds its minimum so stale values from an earlier load never leak in.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            row_min_d[i] = row_min_q[i];
            if (accept && (wr_row == 3'(i))) begin
                if (wr_first || (in_data < row_min_q[i])) begin
                    row_min_d[i] = in_data;
                end
            end
        end
        rowmin_out_d = row_min_q[W];
    end

    always_ff @(posedge CLK) begin
        for (int i = 0; i < N; i++) begin
            row_min_q[i] <= row_min_d[i];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rowmin_out_q <= '0;
        end else begin
            rowmin_out_q <= rowmin_out_d;
        end
    end

    assign RowMin = rowmin_out_q;
`endif
endmodule

// File: doc/cost_loader.md
COST_LOADER -- requirements
Module: cost_loader

Interface
REQ-001 SHALL have parameter N, default 8, meaning the number of workers and the number of jobs (table is N x N).
REQ-002 SHALL have parameter COST_W, default 7, meaning the bit width of one cost entry.
REQ-003 SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port clr  input  1  restart-load request.
REQ-006 SHALL have port in_valid  input  1  upstream cost word valid.
REQ-007 SHALL have port in_ready  output  1  block accepts a cost word this cycle.
REQ-008 SHALL have port in_data  input  COST_W  cost word; entries arrive row-major, worker 0 job 0 first.
REQ-009 SHALL have port Load_done  output  1  table fully loaded; downstream may start enumeration.
REQ-010 SHALL have port W  input  3  worker index for lookup.
REQ-011 SHALL have port J  input  3  job index for lookup.
REQ-012 SHALL have port Cost  output  COST_W  registered cost of entry (W,J).

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, READY; IDLE->LOAD unconditionally after one cycle; LOAD->READY on acceptance of entry N*N-1; READY holds until clr.
REQ-014 SHALL drive in_ready combinationally as (state==LOAD) and not clr.
REQ-015 SHALL accept a word only when in_valid and in_ready are both 1; an accepted word is written to entry (cnt/N, cnt%N), then the 6-bit load counter cnt increments.
REQ-016 SHALL hold cnt and write nothing when in_valid is 0 during LOAD (stalls of any length allowed).
REQ-017 SHALL drive Load_done registered: 1 in READY only, 0 in IDLE and LOAD.
REQ-018 SHALL present Cost = table[W][J] one cycle after W/J are sampled (1-cycle read latency); reads are legal in every state.
REQ-019 SHALL return the old entry value on a same-cycle read and write to the same entry.
REQ-020 SHALL, on clr in LOAD or READY, go to IDLE next cycle and zero cnt; table contents are retained and are not cleared; clr wins over a simultaneous transfer (the word is not accepted).
REQ-021 SHALL ignore clr in IDLE.

Reset
REQ-022 SHALL, on RST, set state=IDLE, cnt=0, Load_done=0, Cost=0; in_ready is 0 during and one cycle after reset.
REQ-023 SHALL abandon any partial load on RST mid-LOAD; the next load restarts at entry (0,0).
REQ-024 SHALL leave table contents undefined after RST (no reset on storage).

Configuration
REQ-025 SHALL, with macro COST_LOADER_ROWMIN_EN defined, add output RowMin (COST_W bits) = minimum of row W, with the same 1-cycle latency as Cost.
REQ-026 SHALL, when COST_LOADER_ROWMIN_EN is defined, track the row minimum during LOAD: each row minimum is set to the first accepted entry of its row, then updated with min(current, new) for the remaining entries.
REQ-027 SHALL, without COST_LOADER_ROWMIN_EN, omit the RowMin port and all row-minimum logic.

Structure
REQ-028 SHALL place constants N, COST_W, the cnt width, and the state enum (IDLE/LOAD/READY) in shared package jam_pkg, which is also used by the permutation/cost block.
REQ-029 SHALL contain one sub-module, cost_table_rf: N*N x COST_W register file with one write port and one registered read port.

Verification
REQ-030 SHALL cover the directed scenario: load entries 0..63 with value (w*8+j)%100 and no stalls -> Load_done rises the cycle after the 64th accept; W=3,J=5 gives Cost=29 next cycle.
REQ-031 SHALL cover the directed scenario: in_valid toggling every other cycle -> exactly 64 accepts; Load_done is 1 after 127 active cycles; no entry is skipped.
REQ-032 SHALL cover the directed scenario: clr asserted with in_valid at entry 20 -> that word is not accepted; IDLE then LOAD; the next word goes to entry (0,0); entry 25 still reads its old value.
REQ-033 SHALL cover the directed scenario: RST pulsed at entry 40 -> Load_done=0, Cost=0, in_ready=0 for one cycle; reload completes normally.
REQ-034 SHALL cover the directed scenario: with COST_LOADER_ROWMIN_EN, row 2 = {50,7,99,7,120,8,60,3} -> RowMin=3 for W=2.
REQ-035 SHALL cover the directed scenario: same-cycle write and read of entry (7,7) holding 11 while writing 90 -> Cost=11, then 90 on the following read.
